keypad_display_ctrl: RTL and testbench
======================================

# keypad_display_ctrl

Parametrised keypad-scan and multi-digit seven-segment controller for the two-phase-clocked ASIC top level. It scans a ROWS×COLS matrix keypad and debounces presses. Accepted key codes shift into a DIGITS-deep history. The display is time-multiplexed across DIGITS digits, showing either the key history or the raw switch inputs. It generalises the fixed 4×4, 2-digit scanner/display of the current top level with configurable size, debounce, and per-slot blanking.

## Interface
- ROWS, 4, keypad rows (ROWS*COLS ≤ 16)
- COLS, 4, keypad columns
- DIGITS, 4, display digits and history depth
- SCAN_DIV, 4, cycles each column is driven before rows are sampled (≥2)
- DEBOUNCE, 3, consecutive matching samples to accept a press or release (≥2)
- REFRESH_DIV, 8, cycles per digit slot (≥2)

- ph1  in  1  clock phase 1, non-overlapping with ph2
- ph2  in  1  clock phase 2
- reset  in  1  reset, synchronous, active-low
- mode  in  1  display source: 0 = key history, 1 = sw
- sw  in  4*DIGITS  switch nibbles; digit d = sw[4d+3:4d]
- rows  in  ROWS  keypad rows, active-low, externally pulled up
- columns  out  COLS  column drive, active-low one-hot
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- digit_en  out  DIGITS  digit enable, active-high one-hot or all-zero
- key_valid  out  1  one-cycle pulse on accepted press
- key_code  out  4  code of last accepted key

## Operation
- Scanner FSM states:
  - SCAN: drive column c for SCAN_DIV cycles and sample rows in the last cycle. If any row is low, latch the row pattern and go to DEBOUNCE with cnt=1. Otherwise c = (c+1) mod COLS and stay in SCAN.
  - DEBOUNCE: hold column c and sample every cycle. A pattern equal to the latched one increments cnt. Any other pattern returns to SCAN at the next column. When cnt reaches DEBOUNCE, go to HELD.
  - HELD: hold column c. Require DEBOUNCE consecutive all-high samples, then return to SCAN at the next column. A low sample resets the release count. Other keys pressed meanwhile are ignored.
- Multiple rows low: the lowest row index wins.
- Code for row r, column c:
  - 4×4: KEYMAP[r][c] with layout 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
  - Any other size: r*COLS+c.
- On accept:
  - key_code ← code.
  - hist[0] ← code and hist[i] ← hist[i-1]; hist[DIGITS-1] is discarded.
- Display:
  - Slot counter runs 0..REFRESH_DIV-1, then the digit index d advances mod DIGITS.
  - Cycle 0 of each slot: digit_en = 0 (anti-ghost blank).
  - Remaining cycles: digit_en = one-hot(d).
  - seg = hex7seg(mode ? sw nibble d : hist[d]).
  - mode and sw are used combinationally through a register stage with no capture, so a change shows by the next slot at the latest.

## Timing
- Registers are ph2-transparent master latch plus ph1-transparent slave latch. Inputs are sampled at ph2 falling edge; outputs change during ph1 high. One cycle = one ph1+ph2 period.
- reset low at a ph2 fall takes effect after the following ph1. Reset mid-scan or mid-debounce abandons the press and produces no key_valid.
- Reset values:
  - FSM = SCAN, c = 0, columns = ~1 (column 0 driven).
  - hist and key_code = 0.
  - key_valid = 0.
  - d = 0, slot = 0, digit_en = 0, seg = 7'b1000000 ("0").
- Press latency: detect at the SCAN sample cycle. key_valid is high the cycle after cnt reaches DEBOUNCE, which is DEBOUNCE cycles after detection.
- key_valid is exactly 1 cycle per press, however long the key is held.
- Counters wrap: c at COLS-1→0, d at DIGITS-1→0, slot at REFRESH_DIV-1→0.

## Structure
- Package keypad_display_pkg holds:
  - scan_state_t {SCAN, DEBOUNCE, HELD}
  - KEYMAP 4×4 constant
  - hex7seg function (0–F, active-low)
  - SEG_BLANK constant
- One sub-module, seg_mux: slot/digit counters, blank cycle, source select, and hex7seg decode.
- The scanner FSM and history stay in keypad_display_ctrl.
- Use the codebase's two-phase flop cell for all state.

## Test plan
All scenarios use default parameters.
1. Reset: hold reset=0 for 3 cycles.
   - columns=4'b1110, digit_en=0, seg=7'b1000000, key_valid=0.
2. Press row 1, column 2 (key 6) for 40 cycles.
   - Exactly one key_valid pulse, key_code=6, hist={0,0,0,6}.
   - columns stay 4'b1011 until 3 all-high samples follow release.
3. Bounce: row 1 low for 1 cycle, then high, at the column-0 sample.
   - No key_valid, and scanning moves to column 1.
4. Enter keys 1, 2, 3, 4, 5.
   - hist={2,3,4,5} with the oldest key discarded.
   - With mode=0, slot d=0 shows "5" (7'b0010010) and digit_en toggles 0 → 4'b0001 over 8 cycles.
5. mode=1, sw=16'hA0F3.
   - Slots show 3, F, 0, A in order, each preceded by one blank cycle.
6. Hold rows 0 and 2 low together, then assert reset during DEBOUNCE.
   - Row 0 wins, no key_valid fires, and after reset hist=0 and columns=4'b1110.

Source files
------------

// File: rtl/keypad_display_pkg.sv
// Shared types and constants for the keypad scanner / seven-segment display controller.
package keypad_display_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7f;

  // Physical 4x4 legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D, indexed [row][col]
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: hex7seg = 7'b1000000;
      4'h1: hex7seg = 7'b1111001;
      4'h2: hex7seg = 7'b0100100;
      4'h3: hex7seg = 7'b0110000;
      4'h4: hex7seg = 7'b0011001;
      4'h5: hex7seg = 7'b0010010;
      4'h6: hex7seg = 7'b0000010;
      4'h7: hex7seg = 7'b1111000;
      4'h8: hex7seg = 7'b0000000;
      4'h9: hex7seg = 7'b0010000;
      4'hA: hex7seg = 7'b0001000;
      4'hB: hex7seg = 7'b0000011;
      4'hC: hex7seg = 7'b1000110;
      4'hD: hex7seg = 7'b0100001;
      4'hE: hex7seg = 7'b0000110;
      4'hF: hex7seg = 7'b0001110;
      default: hex7seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/keypad_display_ctrl_seg_mux.sv
// Display multiplexer: slot/digit counters, anti-ghost blank cycle, source select and decode.
module seg_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 8
) (
  input  logic                ph1,
  input  logic                ph2,
  input  logic                reset,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] sw,
  input  logic [4*DIGITS-1:0] hist,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   digit_en
);
  import keypad_display_pkg::*;

  localparam int SLW = $clog2(REFRESH_DIV);
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef struct packed {
    logic [SLW-1:0] slot;
    logic [DW-1:0]  d;
    logic [6:0]     seg;
  } mux_t;

  localparam mux_t RST = '{slot: '0, d: '0, seg: 7'b1000000};

  mux_t s, n;
  logic [3:0] nib;

  always_comb begin
    n = s;
    if (s.slot == SLW'(REFRESH_DIV - 1)) begin
      n.slot = '0;
      n.d    = (s.d == DW'(DIGITS - 1)) ? '0 : s.d + 1'b1;
    end else begin
      n.slot = s.slot + 1'b1;
    end
    // Decode for the digit that will be shown next cycle so seg and digit_en line up
    nib   = mode ? sw[int'(n.d)*4 +: 4] : hist[int'(n.d)*4 +: 4];
    n.seg = hex7seg(nib);
  end

  tp_reg #(.W($bits(mux_t)), .INIT(RST)) u_state (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(n), .q(s)
  );

  assign seg      = s.seg;
  assign digit_en = (s.slot == '0) ? '0 : (DIGITS'(1) << s.d);
endmodule

// File: rtl/tp_reg.sv
// Two-phase register cell: master captures at the ph2 falling edge, slave updates on ph1.
module tp_reg #(
  parameter int           W    = 1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         ph1,
  input  logic         ph2,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;

  // Edge form of the ph2-transparent master / ph1-transparent slave latch pair
  always_ff @(negedge ph2) m <= reset ? d : INIT;
  always_ff @(posedge ph1) q <= m;
endmodule

// File: rtl/keypad_display_ctrl.sv
// Matrix keypad scanner with debounce and key history, driving a multiplexed 7-seg display.
module keypad_display_ctrl #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 4,
  parameter int DEBOUNCE    = 3,
  parameter int REFRESH_DIV = 8
) (
  input  logic                ph1,
  input  logic                ph2,
  input  logic                reset,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] sw,
  input  logic [ROWS-1:0]     rows,
  output logic [COLS-1:0]     columns,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   digit_en,
  output logic                key_valid,
  output logic [3:0]          key_code
);
  import keypad_display_pkg::*;

  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int BW    = $clog2(DEBOUNCE + 1);
  localparam scan_state_t ST_DEB = keypad_display_pkg::DEBOUNCE;

  typedef struct packed {
    scan_state_t              st;
    logic [CW-1:0]            col;
    logic [DIV_W-1:0]         div;
    logic [BW-1:0]            cnt;
    logic [ROWS-1:0]          pat;
    logic [3:0]               code;
    logic                     kv;
    logic [DIGITS-1:0][3:0]   hist;
  } scan_t;

  scan_t s, n;
  int         rsel;
  logic [3:0] code;
  logic [CW-1:0] next_col;

  // Lowest-index low row in the latched pattern wins
  always_comb begin
    rsel = 0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (!s.pat[r]) rsel = r;
    if (ROWS == 4 && COLS == 4) code = KEYMAP[2'(rsel)][2'(s.col)];
    else                        code = 4'(rsel * COLS + int'(s.col));
  end

  assign next_col = (s.col == CW'(COLS - 1)) ? '0 : s.col + 1'b1;

  always_comb begin
    n    = s;
    n.kv = 1'b0;
    case (s.st)
      SCAN: begin
        if (s.div == DIV_W'(SCAN_DIV - 1)) begin
          n.div = '0;
          if (!(&rows)) begin
            n.st  = ST_DEB;
            n.pat = rows;
            n.cnt = BW'(1);
          end else begin
            n.col = next_col;
          end
        end else begin
          n.div = s.div + 1'b1;
        end
      end
      ST_DEB: begin
        if (rows == s.pat) begin
          n.cnt = s.cnt + 1'b1;
          if (s.cnt == BW'(DEBOUNCE - 1)) begin
            n.st      = HELD;
            n.cnt     = '0;
            n.kv      = 1'b1;
            n.code    = code;
            n.hist[0] = code;
            for (int i = 1; i < DIGITS; i++) n.hist[i] = s.hist[i-1];
          end
        end else begin
          n.st  = SCAN;
          n.cnt = '0;
          n.col = next_col;
        end
      end
      HELD: begin
        // Any low row restarts the release count; other keys are otherwise ignored
        if (&rows) begin
          if (s.cnt == BW'(DEBOUNCE - 1)) begin
            n.st  = SCAN;
            n.cnt = '0;
            n.col = next_col;
          end else begin
            n.cnt = s.cnt + 1'b1;
          end
        end else begin
          n.cnt = '0;
        end
      end
      default: n.st = SCAN;
    endcase
  end

  tp_reg #(.W($bits(scan_t))) u_state (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(n), .q(s)
  );

  assign columns   = ~(COLS'(1) << s.col);
  assign key_valid = s.kv;
  assign key_code  = s.code;

  seg_mux #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) u_seg_mux (
    .ph1(ph1), .ph2(ph2), .reset(reset), .mode(mode), .sw(sw),
    .hist(s.hist), .seg(seg), .digit_en(digit_en)
  );
endmodule

// File: tb/tb_keypad_display_ctrl.sv
// Bench for keypad_display_ctrl: keypad matrix model, directed scenarios and random key entry.
module tb_keypad_display_ctrl;
  logic        ph1, ph2, reset, mode;
  logic [15:0] sw;
  logic [3:0]  rows, columns, digit_en, key_code;
  logic [6:0]  seg;
  logic        key_valid;

  logic [3:0][3:0] keys;   // keys[r][c] pressed
  logic [3:0]      glitch; // forces rows low regardless of columns
  logic [3:0][3:0] mh;     // expected history, mh[0] newest
  int t, checks, errors;

  logic [3:0] KM  [4][4] = '{'{4'h1,4'h2,4'h3,4'hA}, '{4'h4,4'h5,4'h6,4'hB},
                             '{4'h7,4'h8,4'h9,4'hC}, '{4'hE,4'h0,4'hF,4'hD}};
  logic [6:0] SEG [16]   = '{7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78,
                             7'h00,7'h10,7'h08,7'h03,7'h46,7'h21,7'h06,7'h0e};

  keypad_display_ctrl dut (
    .ph1(ph1), .ph2(ph2), .reset(reset), .mode(mode), .sw(sw), .rows(rows),
    .columns(columns), .seg(seg), .digit_en(digit_en),
    .key_valid(key_valid), .key_code(key_code)
  );

  initial begin
    ph1 = 0; ph2 = 0;
    forever begin #1 ph1 = 1; #3 ph1 = 0; #1 ph2 = 1; #3 ph2 = 0; #2; end
  end

  always_comb begin
    rows = ~glitch;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !columns[c]) rows[r] = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge ph1);
    t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] code);
    for (int i = 3; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = code;
  endtask

  // Reset held for 3 cycles; t counts cycles from the first cycle with reset released
  task automatic rst();
    reset = 0;
    repeat (3) tick();
    reset = 1;
    t = 0;
    mh = '0;
  endtask

  // Press rows r1/r2 on column c; exactly one accept expected, lowest row wins
  task automatic press(input int r1, input int r2, input int c, input int hold, input int gap);
    int n;
    logic [3:0] code;
    n = 0;
    code = KM[(r1 < r2) ? r1 : r2][c];
    keys[r1][c] = 1'b1;
    keys[r2][c] = 1'b1;
    repeat (hold) begin if (key_valid) n++; tick(); end
    keys = '0;
    repeat (gap) begin if (key_valid) n++; tick(); end
    chk("press_kv_count", n, 1);
    chk("press_key_code", key_code, code);
    push(code);
  endtask

  // Walk two full refresh rounds; slot and digit follow from cycles since reset
  task automatic disp(input string tag, input logic [3:0][3:0] e);
    repeat (64) begin
      int sl, dd;
      sl = t % 8;
      dd = (t / 8) % 4;
      chk({tag, "_digit_en"}, digit_en, (sl == 0) ? 0 : (1 << dd));
      if (sl != 0) chk({tag, "_seg"}, seg, SEG[e[dd]]);
      tick();
    end
  endtask

  initial begin
    int n;
    logic [3:0][3:0] e;
    checks = 0; errors = 0; t = 0;
    reset = 0; mode = 0; sw = '0; keys = '0; glitch = '0; mh = '0;

    // 1: reset state
    rst();
    chk("rst_columns", columns, 4'b1110);
    chk("rst_digit_en", digit_en, 0);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);

    // 2: key 6 (row 1, col 2) held 40 cycles; col 2 sampled at t=11, accept 3 cycles later
    keys[1][2] = 1'b1;
    n = 0;
    repeat (40) begin
      if (t == 14) chk("t2_kv_latency", key_valid, 1);
      if (t >= 8) chk("t2_col_held", columns, 4'b1011);
      if (key_valid) n++;
      tick();
    end
    keys = '0;
    repeat (4) begin
      chk("t2_col_release", columns, (t < 43) ? 4'b1011 : 4'b0111);
      if (key_valid) n++;
      tick();
    end
    repeat (10) begin if (key_valid) n++; tick(); end
    chk("t2_kv_count", n, 1);
    chk("t2_key_code", key_code, 4'h6);
    push(4'h6);
    disp("t2_disp", mh);

    // 3: one-cycle bounce on row 1 at the column-0 sample
    rst();
    repeat (3) tick();
    glitch = 4'b0010;
    tick();
    glitch = '0;
    chk("t3_col_deb", columns, 4'b1110);
    tick();
    chk("t3_col_next", columns, 4'b1101);
    n = 0;
    repeat (20) begin if (key_valid) n++; tick(); end
    chk("t3_kv_count", n, 0);

    // 4: keys 1..5, oldest drops out
    rst();
    press(0, 0, 0, 35, 12);
    press(0, 0, 1, 35, 12);
    press(0, 0, 2, 35, 12);
    press(1, 1, 0, 35, 12);
    press(1, 1, 1, 35, 12);
    e = {4'h2, 4'h3, 4'h4, 4'h5};
    chk("t4_model_hist", mh, e);
    disp("t4_disp", e);

    // random key entry against the history model
    repeat (8) begin
      int r, c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      press(r, r, c, $urandom_range(30, 45), $urandom_range(8, 20));
    end
    disp("rnd_disp", mh);

    // 5: switch source
    mode = 1;
    sw = 16'hA0F3;
    tick();
    disp("t5_disp", {4'hA, 4'h0, 4'hF, 4'h3});
    sw = 16'($urandom);
    tick();
    disp("rnd_sw_disp", sw);
    mode = 0;
    tick();

    // 6: rows 0 and 2 together -> row 0 code; then reset abandons a press in debounce
    press(0, 2, 1, 35, 12);
    rst();
    keys[0][0] = 1'b1;
    keys[2][0] = 1'b1;
    n = 0;
    repeat (4) begin if (key_valid) n++; tick(); end
    chk("t6_col_deb", columns, 4'b1110);
    reset = 0;
    repeat (3) begin if (key_valid) n++; tick(); end
    keys = '0;
    reset = 1;
    t = 0;
    mh = '0;
    chk("t6_rst_columns", columns, 4'b1110);
    chk("t6_rst_key_code", key_code, 0);
    repeat (20) begin if (key_valid) n++; tick(); end
    chk("t6_kv_count", n, 0);
    disp("t6_disp", mh);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
